mux_2_to_1: RTL and testbench

Parameterised 2-to-1 multiplexer with an active-high output enable. It drives a combinational selected output and a registered copy of that output with a valid flag. It is a leaf datapath-steering primitive used wherever a block picks between two equal-width sources. The combinational path gives same-cycle steering; the registered path gives a clean flop boundary.

---
 rtl/mux_pkg.sv | 19 +
 rtl/mux_2_to_1_core.sv | 17 +
 rtl/mux_2_to_1.sv | 44 ++++
 tb/tb_mux_2_to_1.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared steering definitions: select encodings and the gated 2:1 select
// function used by the mux_2_to_1 family and other steering blocks.
package mux_pkg;

    localparam int   MAX_W = 1024;
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Callers zero-extend narrower operands to MAX_W and truncate the result.
    function automatic logic [MAX_W-1:0] mux2_sel(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input logic             sel,
        input logic             en
    );
        return en ? ((sel == SEL_B) ? b : a) : '0;
    endfunction

endpackage

// File: rtl/mux_2_to_1_core.sv
// Combinational select-and-gate: picks a or b by sel and forces zero when
// the enable is low. No state, no clock.
module mux_2_to_1_core #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic             en,
    output logic [WIDTH-1:0] y
);

    import mux_pkg::*;

    assign y = WIDTH'(mux2_sel(MAX_W'(a), MAX_W'(b), sel, en));

endmodule

// File: rtl/mux_2_to_1.sv
// 2:1 mux with output enable: same-cycle steered output plus a registered
// copy and a valid flag that tracks the enable one cycle later.
module mux_2_to_1 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic             en,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             y_q_vld
);

    logic [WIDTH-1:0] y_p1;
    logic             vld_p1;

    mux_2_to_1_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a   (a),
        .b   (b),
        .sel (sel),
        .en  (en),
        .y   (y)
    );

    // Stage p1: y and en captured every edge; a disabled cycle loads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_p1   <= '0;
            vld_p1 <= 1'b0;
        end else begin
            y_p1   <= y;
            vld_p1 <= en;
        end
    end

    assign y_q     = y_p1;
    assign y_q_vld = vld_p1;

endmodule

// File: tb/tb_mux_2_to_1.sv
// Self-checking bench for mux_2_to_1 at WIDTH=1 and WIDTH=8; registered
// outputs are checked against a queue of expected {vld, data} entries.
module tb_mux_2_to_1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       a1, b1, sel1, en1, y1, y_q1, vld1;
    logic [7:0] a8, b8, y8, y_q8;
    logic       sel8, en8, vld8;

    logic [1:0] q1[$];
    logic [8:0] q8[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_2_to_1 #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .sel(sel1), .en(en1),
        .y(y1), .y_q(y_q1), .y_q_vld(vld1)
    );

    mux_2_to_1 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .sel(sel8), .en(en8),
        .y(y8), .y_q(y_q8), .y_q_vld(vld8)
    );

    function automatic logic [7:0] model8(input logic [7:0] a, input logic [7:0] b,
                                          input logic sel, input logic en);
        if (!en) return 8'h00;
        if (sel) return b;
        return a;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        a1 = 1'b1; b1 = 1'b1; sel1 = 1'b0; en1 = 1'b1;
        a8 = 8'h5A; b8 = 8'hC3; sel8 = 1'b0; en8 = 1'b1;
        @(posedge clk); #1;
        total++;
        if (y_q8 !== 8'h00 || vld8 !== 1'b0) begin
            bad++; $display("FAIL reset_w8: y_q=%h vld=%b required y_q=00 vld=0", y_q8, vld8);
        end
        total++;
        if (y_q1 !== 1'b0 || vld1 !== 1'b0) begin
            bad++; $display("FAIL reset_w1: y_q=%b vld=%b required y_q=0 vld=0", y_q1, vld1);
        end
        total++;
        if (y8 !== 8'h5A || y1 !== 1'b1) begin
            bad++; $display("FAIL reset_comb: y8=%h y1=%b required y8=5a y1=1", y8, y1);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_w1_table(input logic en_v);
        logic [2:0] vec [4];
        logic       exp_y [4];
        logic [1:0] e;
        if (en_v) begin
            vec = '{3'b000, 3'b010, 3'b101, 3'b111};  // {a, b, sel}
            exp_y = '{1'b0, 1'b0, 1'b0, 1'b1};
        end else begin
            vec = '{3'b010, 3'b111, 3'b101, 3'b011};
            exp_y = '{1'b0, 1'b0, 1'b0, 1'b0};
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            {a1, b1, sel1} = vec[i];
            en1 = en_v;
            #1;
            total++;
            if (y1 !== exp_y[i]) begin
                bad++; $display("FAIL w1_comb en=%b vec%0d: y=%b required %b", en_v, i, y1, exp_y[i]);
            end
            q1.push_back({en_v, exp_y[i]});
            @(posedge clk); #1;
            total++;
            if (q1.size() == 0) begin
                bad++; $display("FAIL w1_reg: scoreboard empty");
            end else begin
                e = q1.pop_front();
                if ({vld1, y_q1} !== e) begin
                    bad++; $display("FAIL w1_reg en=%b vec%0d: vld,y_q=%b%b required %b", en_v, i, vld1, y_q1, e);
                end
            end
        end
    endtask

    task automatic test_w8_switch();
        logic [8:0] e;
        @(negedge clk);
        a8 = 8'hA5; b8 = 8'h3C; sel8 = 1'b0; en8 = 1'b1;
        #1;
        total++;
        if (y8 !== 8'hA5) begin
            bad++; $display("FAIL w8_sel_a: y=%h required a5", y8);
        end
        sel8 = 1'b1;
        #0;
        #0;
        total++;
        if (y8 !== 8'h3C) begin
            bad++; $display("FAIL w8_sel_b_same_step: y=%h required 3c", y8);
        end
        q8.push_back({1'b1, 8'h3C});
        @(posedge clk); #1;
        total++;
        e = q8.pop_front();
        if ({vld8, y_q8} !== e) begin
            bad++; $display("FAIL w8_switch_reg: vld=%b y_q=%h required vld=%b y_q=%h", vld8, y_q8, e[8], e[7:0]);
        end
    endtask

    task automatic test_registered();
        logic [8:0] e;
        @(negedge clk);
        a8 = 8'h12; b8 = 8'hFF; sel8 = 1'b1; en8 = 1'b1;
        q8.push_back({1'b1, 8'hFF});
        @(posedge clk); #1;
        total++;
        e = q8.pop_front();
        if ({vld8, y_q8} !== e) begin
            bad++; $display("FAIL reg_edge1: vld=%b y_q=%h required vld=%b y_q=%h", vld8, y_q8, e[8], e[7:0]);
        end
        @(negedge clk);
        en8 = 1'b0;
        #1;
        total++;
        if (y8 !== 8'h00) begin
            bad++; $display("FAIL reg_gate_comb: y=%h required 00", y8);
        end
        q8.push_back({1'b0, 8'h00});
        @(posedge clk); #1;
        total++;
        e = q8.pop_front();
        if ({vld8, y_q8} !== e) begin
            bad++; $display("FAIL reg_edge2: vld=%b y_q=%h required vld=%b y_q=%h", vld8, y_q8, e[8], e[7:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_y;
        logic [8:0] e;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            sel8 = 1'($urandom);
            en8  = ($urandom_range(0, 3) != 0);
            exp_y = model8(a8, b8, sel8, en8);
            #1;
            total++;
            if (y8 !== exp_y) begin
                bad++; $display("FAIL b2b_comb %0d: y=%h required %h", i, y8, exp_y);
            end
            q8.push_back({en8, exp_y});
            @(posedge clk); #1;
            total++;
            e = q8.pop_front();
            if ({vld8, y_q8} !== e) begin
                bad++; $display("FAIL b2b_reg %0d: vld=%b y_q=%h required vld=%b y_q=%h", i, vld8, y_q8, e[8], e[7:0]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [8:0] e;
        @(negedge clk);
        a8 = 8'h00; b8 = 8'hFF; sel8 = 1'b1; en8 = 1'b1;
        @(posedge clk); #1;
        total++;
        if (y_q8 !== 8'hFF || vld8 !== 1'b1) begin
            bad++; $display("FAIL areset_pre: vld=%b y_q=%h required vld=1 y_q=ff", vld8, y_q8);
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (y_q8 !== 8'h00 || vld8 !== 1'b0) begin
            bad++; $display("FAIL areset_immediate: vld=%b y_q=%h required vld=0 y_q=00", vld8, y_q8);
        end
        a8 = 8'h81; sel8 = 1'b0;
        #1;
        total++;
        if (y8 !== 8'h81) begin
            bad++; $display("FAIL areset_comb: y=%h required 81", y8);
        end
        @(posedge clk); #1;
        total++;
        if (y_q8 !== 8'h00 || vld8 !== 1'b0) begin
            bad++; $display("FAIL areset_hold: vld=%b y_q=%h required vld=0 y_q=00", vld8, y_q8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a8 = 8'h3C; sel8 = 1'b0; en8 = 1'b1;
        q8.push_back({1'b1, 8'h3C});
        @(posedge clk); #1;
        total++;
        e = q8.pop_front();
        if ({vld8, y_q8} !== e) begin
            bad++; $display("FAIL areset_release: vld=%b y_q=%h required vld=%b y_q=%h", vld8, y_q8, e[8], e[7:0]);
        end
    endtask

    initial begin
        test_reset();
        test_w1_table(1'b1);
        test_w1_table(1'b0);
        test_w8_switch();
        test_registered();
        test_back_to_back();
        test_async_reset();
        total++;
        if (q8.size() != 0 || q1.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain: q8=%0d q1=%0d required 0", q8.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
